operand_unit_arbiter: RTL and testbench

- Shares one source_operand datapath (inputs R[31:0], Imm[21:0], IS[3:0]; output N[31:0]) between two requesters, e.g. the execute-stage ALU operand path and the load/store address path.
- Arbitration is round-robin with valid/ready request handshakes.
- The block registers the granted operands, drives the shared unit, captures N and returns it through a per-requester response handshake.
- Sits between the decode/issue logic and the single source_operand instance.

---
 rtl/operand_unit_arbiter.sv | 112 +++++++++++
 tb/tb_operand_unit_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_unit_arbiter.sv
// Round-robin arbiter sharing one source_operand unit between two requesters.
// Operands are registered on grant, the result is captured after one EXEC cycle and held until acked.
//
// state | meaning
// IDLE  | no operation in flight; winner gets ready combinationally
// EXEC  | held operands drive the shared unit; su_n captured at end of cycle
// RESP  | result presented to the granted requester until its ack
module operand_unit_arbiter #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 22,
    parameter int IS_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_r,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic [IS_W-1:0]   req0_is,
    output logic              resp0_valid,
    input  logic              resp0_ack,
    output logic [DATA_W-1:0] resp0_n,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_r,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic [IS_W-1:0]   req1_is,
    output logic              resp1_valid,
    input  logic              resp1_ack,
    output logic [DATA_W-1:0] resp1_n,
    output logic [DATA_W-1:0] su_r,
    output logic [IMM_W-1:0]  su_imm,
    output logic [IS_W-1:0]   su_is,
    input  logic [DATA_W-1:0] su_n,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   ptr;
    logic   win0, win1;
    logic   acc0, acc1;
    logic   owner_ack;

    // ptr names the requester preferred when both are valid
    assign win0      = req0_valid && (!req1_valid || !ptr);
    assign win1      = req1_valid && (!req0_valid || ptr);
    assign acc0      = req0_valid && req0_ready;
    assign acc1      = req1_valid && req1_ready;
    assign owner_ack = grant_id ? resp1_ack : resp0_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc0 || acc1) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (owner_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = (state == IDLE) && win0;
        req1_ready  = (state == IDLE) && win1;
        busy        = (state != IDLE);
        resp0_valid = (state == RESP) && !grant_id;
        resp1_valid = (state == RESP) && grant_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            grant_id <= 1'b0;
            su_r     <= '0;
            su_imm   <= '0;
            su_is    <= '0;
            resp0_n  <= '0;
            resp1_n  <= '0;
        end else begin
            if (state == IDLE && (acc0 || acc1)) begin
                grant_id <= acc1;
                ptr      <= acc0;
                su_r     <= acc1 ? req1_r   : req0_r;
                su_imm   <= acc1 ? req1_imm : req0_imm;
                su_is    <= acc1 ? req1_is  : req0_is;
            end
            // Only the owner's result register moves; the other keeps its last value
            if (state == EXEC) begin
                if (grant_id) begin
                    resp1_n <= su_n;
                end else begin
                    resp0_n <= su_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_unit_arbiter.sv
// Self-checking bench for operand_unit_arbiter: directed sequences, a sweep table
// and randomized traffic against a transaction-level reference model.
module tb_operand_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ack;
    logic [31:0] req0_r, resp0_n;
    logic [21:0] req0_imm;
    logic [3:0]  req0_is;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ack;
    logic [31:0] req1_r, resp1_n;
    logic [21:0] req1_imm;
    logic [3:0]  req1_is;
    logic [31:0] su_r, su_n;
    logic [21:0] su_imm;
    logic [3:0]  su_is;
    logic        busy, grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared source_operand unit
    assign su_n = su_r + {28'b0, su_is};

    operand_unit_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r(req0_r),
        .req0_imm(req0_imm), .req0_is(req0_is), .resp0_valid(resp0_valid),
        .resp0_ack(resp0_ack), .resp0_n(resp0_n),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r(req1_r),
        .req1_imm(req1_imm), .req1_is(req1_is), .resp1_valid(resp1_valid),
        .resp1_ack(resp1_ack), .resp1_n(resp1_n),
        .su_r(su_r), .su_imm(su_imm), .su_is(su_is), .su_n(su_n),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        logic [31:0] r;
        logic [21:0] imm;
        logic [3:0]  is;
        logic [31:0] exp_n;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_su_r"}, su_r, 0);
        chk({tag, "_su_imm"}, su_imm, 0);
        chk({tag, "_su_is"}, su_is, 0);
        chk({tag, "_resp0_n"}, resp0_n, 0);
        chk({tag, "_resp1_n"}, resp1_n, 0);
        chk({tag, "_resp0_valid"}, resp0_valid, 0);
        chk({tag, "_resp1_valid"}, resp1_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    // Called at negedge+1; waits a bounded number of cycles for the requester's ready
    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((id == 0) ? req0_ready : req1_ready) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_op(input int id, input logic [31:0] r, input logic [21:0] imm,
                         input logic [3:0] is, input logic [31:0] exp_n, input string tag);
        bit ok;
        @(negedge clk);
        if (id == 0) begin
            req0_valid = 1; req0_r = r; req0_imm = imm; req0_is = is;
        end else begin
            req1_valid = 1; req1_r = r; req1_imm = imm; req1_is = is;
        end
        #1;
        wait_ready(id, ok);
        chk({tag, "_ready"}, ok, 1);
        if (!ok) begin
            req0_valid = 0; req1_valid = 0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1;
        chk({tag, "_su_r"}, su_r, r);
        chk({tag, "_su_imm"}, su_imm, imm);
        chk({tag, "_su_is"}, su_is, is);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_grant_id"}, grant_id, id);
        chk({tag, "_exec_novalid"}, {resp0_valid, resp1_valid}, 0);
        @(negedge clk);
        #1;
        chk({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, (id == 0) ? 2'b01 : 2'b10);
        chk({tag, "_resp_n"}, (id == 0) ? resp0_n : resp1_n, exp_n);
        if (id == 0) resp0_ack = 1; else resp1_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp0_ack = 0; resp1_ack = 0;
        #1;
        chk({tag, "_valid_drop"}, {resp0_valid, resp1_valid}, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit          pend[2];
        logic [31:0] pr[2];
        logic [21:0] pimm[2];
        logic [3:0]  pis[2];
        bit          ack[2];
        bit          e_rdy0, e_rdy1;
        bit          m_act, m_own, m_pref, m_gid;
        int          m_age;
        logic [31:0] m_hr;
        logic [21:0] m_himm;
        logic [3:0]  m_his;
        logic [31:0] m_last[2];
        logic [31:0] held_n;

        rst_n = 0;
        req0_valid = 0; req0_r = 0; req0_imm = 0; req0_is = 0; resp0_ack = 0;
        req1_valid = 0; req1_r = 0; req1_imm = 0; req1_is = 0; resp1_ack = 0;
        #1;
        chk_all_zero("reset");
        chk("reset_ready", {req0_ready, req1_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // Contention straight after reset: requester 0 first, then 1
        @(negedge clk);
        req0_valid = 1; req0_r = 32'h10; req0_is = 4'h1; req0_imm = 22'h0;
        req1_valid = 1; req1_r = 32'h20; req1_is = 4'h2; req1_imm = 22'h0;
        #1;
        chk("cont_ready", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("cont_gid0", grant_id, 0);
        chk("cont_ready1_exec", req1_ready, 0);
        @(negedge clk);
        #1;
        chk("cont_resp0_valid", resp0_valid, 1);
        chk("cont_resp0_n", resp0_n, 32'h11);
        resp0_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp0_ack = 0;
        #1;
        wait_ready(1, ok);
        chk("cont_ready1", ok, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        #1;
        chk("cont_gid1", grant_id, 1);
        @(negedge clk);
        #1;
        chk("cont_resp1_valid", resp1_valid, 1);
        chk("cont_resp1_n", resp1_n, 32'h22);
        chk("cont_resp0_n_kept", resp0_n, 32'h11);
        resp1_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp1_ack = 0;

        do_op(0, 32'hE0000003, 22'h231113, 4'h5, 32'hE0000008, "single");
        chk("single_resp1_n_kept", resp1_n, 32'h22);

        // Response held while requester 1 waits; stray ack from requester 1 ignored
        @(negedge clk);
        req0_valid = 1; req0_r = 32'hABCD0000; req0_is = 4'h3; req0_imm = 22'h1;
        #1;
        chk("hold_ready0", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 1; req1_r = 32'h55; req1_is = 4'h7; req1_imm = 22'h2;
        #1;
        chk("hold_ready1_exec", req1_ready, 0);
        held_n = 32'hABCD0003;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            resp1_ack = (k == 2);
            #1;
            chk("hold_resp0_valid", resp0_valid, 1);
            chk("hold_resp0_n", resp0_n, held_n);
            chk("hold_ready1", req1_ready, 0);
            chk("hold_resp1_valid", resp1_valid, 0);
        end
        resp1_ack = 0;
        resp0_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp0_ack = 0;
        #1;
        chk("hold_drop", resp0_valid, 0);
        chk("hold_ready1_idle", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        #1;
        chk("hold_gid1", grant_id, 1);
        @(negedge clk);
        #1;
        chk("hold_resp1_n", resp1_n, 32'h5C);
        resp1_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp1_ack = 0;

        // Sweep of all IS codes on requester 1 alone
        for (int i = 0; i < 16; i++) begin
            tbl[i].r     = 32'hE0000003;
            tbl[i].imm   = 22'($urandom);
            tbl[i].is    = 4'(i);
            tbl[i].exp_n = 32'hE0000003 + 32'(i);
        end
        for (int i = 0; i < 16; i++) begin
            do_op(1, tbl[i].r, tbl[i].imm, tbl[i].is, tbl[i].exp_n, $sformatf("sweep%0d", i));
        end

        // Reset in EXEC right after a grant to requester 0 (pointer then favours 1)
        @(negedge clk);
        req0_valid = 1; req0_r = 32'h77; req0_is = 4'h1; req0_imm = 22'h5;
        #1;
        chk("rst_ready0", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        #1;
        chk("rst_busy_exec", busy, 1);
        rst_n = 0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1;
        req0_valid = 1; req0_r = 32'h1; req0_is = 4'h0;
        req1_valid = 1; req1_r = 32'h2; req1_is = 4'h0;
        #1;
        chk("rst_after_ready", {req0_ready, req1_ready}, 2'b10);
        chk("rst_after_noresp", {resp0_valid, resp1_valid}, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        chk("rst_after_resp0_n", resp0_n, 32'h1);
        resp0_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp0_ack = 0;
        #1;
        chk("rst_after_ready1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        chk("rst_after_resp1_n", resp1_n, 32'h2);
        resp1_ack = 1;
        @(posedge clk);
        @(negedge clk);
        resp1_ack = 0;

        // Randomized traffic against a transaction-level model, from a fresh reset
        rst_n = 0;
        #1;
        rst_n = 1;
        m_act = 0; m_own = 0; m_pref = 0; m_gid = 0; m_age = 0;
        m_hr = 0; m_himm = 0; m_his = 0; m_last[0] = 0; m_last[1] = 0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                if (!pend[x] && $urandom_range(0, 2) == 0) begin
                    pend[x] = 1;
                    pr[x]   = $urandom;
                    pimm[x] = 22'($urandom);
                    pis[x]  = 4'($urandom);
                end
                ack[x] = ($urandom_range(0, 2) == 0);
            end
            req0_valid = pend[0]; req0_r = pr[0]; req0_imm = pimm[0]; req0_is = pis[0];
            req1_valid = pend[1]; req1_r = pr[1]; req1_imm = pimm[1]; req1_is = pis[1];
            resp0_ack = ack[0]; resp1_ack = ack[1];
            #1;
            e_rdy0 = !m_act && pend[0] && (!pend[1] || m_pref == 0);
            e_rdy1 = !m_act && pend[1] && (!pend[0] || m_pref == 1);
            chk("rnd_ready0", req0_ready, e_rdy0);
            chk("rnd_ready1", req1_ready, e_rdy1);
            chk("rnd_busy", busy, m_act);
            chk("rnd_gid", grant_id, m_gid);
            chk("rnd_su_r", su_r, m_hr);
            chk("rnd_su_imm", su_imm, m_himm);
            chk("rnd_su_is", su_is, m_his);
            chk("rnd_resp0_valid", resp0_valid, m_act && m_age >= 2 && m_own == 0);
            chk("rnd_resp1_valid", resp1_valid, m_act && m_age >= 2 && m_own == 1);
            chk("rnd_resp0_n", resp0_n, m_last[0]);
            chk("rnd_resp1_n", resp1_n, m_last[1]);
            @(posedge clk);
            if (m_act) begin
                if (m_age == 1) begin
                    m_last[m_own] = m_hr + 32'(m_his);
                    m_age = 2;
                end else if (ack[m_own]) begin
                    m_act = 0;
                end
            end else if (e_rdy0 || e_rdy1) begin
                m_own  = e_rdy1;
                m_gid  = e_rdy1;
                m_pref = !e_rdy1;
                m_act  = 1;
                m_age  = 1;
                m_hr   = pr[m_own];
                m_himm = pimm[m_own];
                m_his  = pis[m_own];
                pend[m_own] = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
